// File: rtl/vga_ball_render_if.sv
// Video-stream bundle between the vga640x480 timing generator, the ball renderer and the DAC.
// The renderer uses the slave modport; the timing source and the display side use master.
interface vga_ball_render_if;
    logic [9:0] col_i;
    logic [9:0] row_i;
    logic       blank_n_i;
    logic       sync_h_i;
    logic       sync_v_i;
    logic       btn_left;
    logic       btn_right;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       sync_h_o;
    logic       sync_v_o;
    logic       blank_n_o;
    logic       frame_tick;
    logic [7:0] miss_cnt;

    modport master (
        output col_i, row_i, blank_n_i, sync_h_i, sync_v_i, btn_left, btn_right,
        input  VGA_R, VGA_G, VGA_B, sync_h_o, sync_v_o, blank_n_o, frame_tick, miss_cnt
    );

    modport slave (
        input  col_i, row_i, blank_n_i, sync_h_i, sync_v_i, btn_left, btn_right,
        output VGA_R, VGA_G, VGA_B, sync_h_o, sync_v_o, blank_n_o, frame_tick, miss_cnt
    );
endinterface

// File: rtl/vga_ball_render.sv
// Bouncing-ball game pixel stage: ball, paddle and a serve/play/miss FSM updated once per frame.
// Optional build macro VGA_BORDER_EN adds a grey 4-pixel frame around the visible area.
module vga_ball_render #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_W     = 64,
    parameter int PADDLE_H     = 8,
    parameter int PADDLE_Y     = 456,
    parameter int PADDLE_SPEED = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 30
) (
    input  logic               clk,
    input  logic               reset,
    vga_ball_render_if.slave   vif
);
    typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, MISS = 2'd2} state_t;

    localparam logic [10:0] BS      = 11'(BALL_SIZE);
    localparam logic [10:0] BV      = 11'(BALL_SPEED);
    localparam logic [10:0] PW      = 11'(PADDLE_W);
    localparam logic [10:0] PH      = 11'(PADDLE_H);
    localparam logic [10:0] PY      = 11'(PADDLE_Y);
    localparam logic [10:0] PV      = 11'(PADDLE_SPEED);
    localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] Y_MAX   = 11'(PADDLE_Y - BALL_SIZE);
    localparam logic [10:0] PAD_MAX = 11'(H_ACTIVE - PADDLE_W);
    localparam logic [9:0]  BALL_X0 = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [9:0]  BALL_Y0 = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [9:0]  PAD_X0  = 10'((H_ACTIVE - PADDLE_W) / 2);
    localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0]  MISS_LAST  = 8'(MISS_FRAMES - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [9:0]  ball_x_r;
    logic [9:0]  ball_y_r;
    logic        dir_x_r;
    logic        dir_y_r;
    logic [9:0]  pad_x_r;
    logic [7:0]  miss_cnt_r;
    logic        tick_prev_r;
    logic        frame_tick_r;
    logic [23:0] rgb_r;
    logic        sync_h_r;
    logic        sync_v_r;
    logic        blank_n_r;

    logic [10:0] col_s, row_s, bx_s, by_s, px_s;
    logic [10:0] pad_nx_s, bx_nx_s, by_nx_s;
    logic        dx_nx_s, dy_nx_s;
    logic        tick_cond_s, tick_s, in_ball_s, in_pad_s, y_hit_s, overlap_s;
    logic [23:0] rgb_s;

    // All geometry is compared at 11 bits so edge arithmetic never wraps.
    assign col_s = {1'b0, vif.col_i};
    assign row_s = {1'b0, vif.row_i};
    assign bx_s  = {1'b0, ball_x_r};
    assign by_s  = {1'b0, ball_y_r};
    assign px_s  = {1'b0, pad_x_r};

    assign tick_cond_s = (vif.col_i == 10'd0) && (vif.row_i == 10'(V_ACTIVE));
    assign tick_s      = tick_cond_s && !tick_prev_r;
    assign in_ball_s   = (col_s >= bx_s) && (col_s < bx_s + BS) && (row_s >= by_s) && (row_s < by_s + BS);
    assign in_pad_s    = (col_s >= px_s) && (col_s < px_s + PW) && (row_s >= PY) && (row_s < PY + PH);
    assign y_hit_s     = dir_y_r && (by_s + BV >= Y_MAX);
    assign overlap_s   = (bx_s + BS > px_s) && (bx_s < px_s + PW);

`ifdef VGA_BORDER_EN
    logic in_border_s;
    assign in_border_s = (col_s < 11'd4) || (col_s >= 11'(H_ACTIVE - 4)) ||
                         (row_s < 11'd4) || (row_s >= 11'(V_ACTIVE - 4));
`endif

    // Pixel colour selection by priority.
    always_comb begin
        rgb_s = 24'h000000;
        if (!vif.blank_n_i) begin
            rgb_s = 24'h000000;
        end else if (in_ball_s && (state_r != MISS)) begin
            rgb_s = 24'hFFFFFF;
        end else if (in_pad_s) begin
            rgb_s = 24'h00FF00;
`ifdef VGA_BORDER_EN
        end else if (in_border_s) begin
            rgb_s = 24'h808080;
`endif
        end else if (state_r == MISS) begin
            rgb_s = 24'hFF0000;
        end else begin
            rgb_s = 24'h0000FF;
        end
    end

    // Next paddle position from the button levels, clamped to the screen.
    always_comb begin
        pad_nx_s = px_s;
        if (vif.btn_left && !vif.btn_right) begin
            pad_nx_s = (px_s >= PV) ? (px_s - PV) : 11'd0;
        end else if (vif.btn_right && !vif.btn_left) begin
            pad_nx_s = (px_s + PV >= PAD_MAX) ? PAD_MAX : (px_s + PV);
        end else begin
            pad_nx_s = px_s;
        end
    end

    // Next ball position and direction for a PLAY tick; the miss case is resolved in the FSM.
    always_comb begin
        bx_nx_s = bx_s;
        dx_nx_s = dir_x_r;
        by_nx_s = by_s;
        dy_nx_s = dir_y_r;
        if (dir_x_r && (bx_s + BV >= X_MAX)) begin
            bx_nx_s = X_MAX;
            dx_nx_s = 1'b0;
        end else if (!dir_x_r && (bx_s <= BV)) begin
            bx_nx_s = 11'd0;
            dx_nx_s = 1'b1;
        end else if (dir_x_r) begin
            bx_nx_s = bx_s + BV;
        end else begin
            bx_nx_s = bx_s - BV;
        end
        if (!dir_y_r && (by_s <= BV)) begin
            by_nx_s = 11'd0;
            dy_nx_s = 1'b1;
        end else if (y_hit_s) begin
            by_nx_s = Y_MAX;
            dy_nx_s = 1'b0;
        end else if (dir_y_r) begin
            by_nx_s = by_s + BV;
        end else begin
            by_nx_s = by_s - BV;
        end
    end

    // Output pipeline: colour and the delayed sync/blank strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_r     <= 24'h000000;
            sync_h_r  <= 1'b1;
            sync_v_r  <= 1'b1;
            blank_n_r <= 1'b0;
        end else begin
            rgb_r     <= rgb_s;
            sync_h_r  <= vif.sync_h_i;
            sync_v_r  <= vif.sync_v_i;
            blank_n_r <= vif.blank_n_i;
        end
    end

    // Game FSM and per-frame position updates, all taken from pre-tick values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= SERVE;
            cnt_r        <= 8'd0;
            ball_x_r     <= BALL_X0;
            ball_y_r     <= BALL_Y0;
            dir_x_r      <= 1'b1;
            dir_y_r      <= 1'b1;
            pad_x_r      <= PAD_X0;
            miss_cnt_r   <= 8'd0;
            tick_prev_r  <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            tick_prev_r  <= tick_cond_s;
            frame_tick_r <= tick_s;
            if (tick_s) begin
                pad_x_r <= pad_nx_s[9:0];
                case (state_r)
                    SERVE: begin
                        if (cnt_r == SERVE_LAST) begin
                            state_r <= PLAY;
                            cnt_r   <= 8'd0;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                    end
                    PLAY: begin
                        ball_x_r <= bx_nx_s[9:0];
                        dir_x_r  <= dx_nx_s;
                        if (y_hit_s && !overlap_s) begin
                            state_r <= MISS;
                            if (miss_cnt_r != 8'hFF) begin
                                miss_cnt_r <= miss_cnt_r + 8'd1;
                            end
                        end else begin
                            ball_y_r <= by_nx_s[9:0];
                            dir_y_r  <= dy_nx_s;
                        end
                    end
                    MISS: begin
                        if (cnt_r == MISS_LAST) begin
                            state_r  <= SERVE;
                            cnt_r    <= 8'd0;
                            ball_x_r <= BALL_X0;
                            ball_y_r <= BALL_Y0;
                            dir_y_r  <= 1'b1;
                            dir_x_r  <= !dir_x_r;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                    end
                    default: begin
                        state_r <= SERVE;
                        cnt_r   <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign vif.VGA_R      = rgb_r[23:16];
    assign vif.VGA_G      = rgb_r[15:8];
    assign vif.VGA_B      = rgb_r[7:0];
    assign vif.sync_h_o   = sync_h_r;
    assign vif.sync_v_o   = sync_v_r;
    assign vif.blank_n_o  = blank_n_r;
    assign vif.frame_tick = frame_tick_r;
    assign vif.miss_cnt   = miss_cnt_r;
endmodule

// File: tb/tb_vga_ball_render.sv
// Directed bench for vga_ball_render: main instance follows a hand-traced game; a shrunken
// instance (short frames, small playfield) drives the miss counter into saturation.
module tb_vga_ball_render;
    logic clk;
    logic reset;
    int   passed;
    int   total;

    vga_ball_render_if m_if();
    vga_ball_render_if s_if();

    vga_ball_render dut (.clk(clk), .reset(reset), .vif(m_if));

    vga_ball_render #(.V_ACTIVE(32), .PADDLE_Y(24), .SERVE_FRAMES(1), .MISS_FRAMES(1)) dut_sat (
        .clk(clk), .reset(reset), .vif(s_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input logic [9:0] c, input logic [9:0] r, input logic [23:0] exp, input string tag);
        m_if.col_i     = c;
        m_if.row_i     = r;
        m_if.blank_n_i = 1'b1;
        cyc();
        chk(tag, {8'd0, m_if.VGA_R, m_if.VGA_G, m_if.VGA_B}, {8'd0, exp});
    endtask

    task automatic tick_main(input int n);
        for (int i = 0; i < n; i++) begin
            m_if.col_i     = 10'd0;
            m_if.row_i     = 10'd480;
            m_if.blank_n_i = 1'b0;
            cyc();
            m_if.col_i = 10'd1;
            cyc();
        end
    endtask

    task automatic tick_sat(input int n);
        for (int i = 0; i < n; i++) begin
            s_if.col_i = 10'd0;
            s_if.row_i = 10'd32;
            cyc();
            s_if.col_i = 10'd1;
            cyc();
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        s_if.col_i = 10'd1; s_if.row_i = 10'd0; s_if.blank_n_i = 1'b0;
        s_if.sync_h_i = 1'b1; s_if.sync_v_i = 1'b1; s_if.btn_left = 1'b0; s_if.btn_right = 1'b0;
        m_if.btn_left = 1'b0; m_if.btn_right = 1'b0;

        // Reset with mid-frame inputs present
        reset = 1'b1;
        m_if.col_i = 10'd316; m_if.row_i = 10'd236; m_if.blank_n_i = 1'b1;
        m_if.sync_h_i = 1'b0; m_if.sync_v_i = 1'b0;
        cyc();
        chk("rst_rgb",    {8'd0, m_if.VGA_R, m_if.VGA_G, m_if.VGA_B}, 32'h0);
        chk("rst_sync_h", {31'd0, m_if.sync_h_o}, 32'd1);
        chk("rst_sync_v", {31'd0, m_if.sync_v_o}, 32'd1);
        chk("rst_blank",  {31'd0, m_if.blank_n_o}, 32'd0);
        chk("rst_tick",   {31'd0, m_if.frame_tick}, 32'd0);
        chk("rst_miss",   {24'd0, m_if.miss_cnt}, 32'd0);

        reset = 1'b0;
        cyc();
        chk("ball_centre", {8'd0, m_if.VGA_R, m_if.VGA_G, m_if.VGA_B}, 32'hFFFFFF);
        chk("sync_h_dly",  {31'd0, m_if.sync_h_o}, 32'd0);
        chk("sync_v_dly",  {31'd0, m_if.sync_v_o}, 32'd0);
        chk("blank_dly",   {31'd0, m_if.blank_n_o}, 32'd1);
        m_if.sync_h_i = 1'b1; m_if.sync_v_i = 1'b1;

        m_if.blank_n_i = 1'b0;
        cyc();
        chk("blanked_ball", {8'd0, m_if.VGA_R, m_if.VGA_G, m_if.VGA_B}, 32'h0);
        probe(10'd0,   10'd0,   24'h0000FF, "bg_origin");
        probe(10'd323, 10'd243, 24'hFFFFFF, "ball_last_px");
        probe(10'd324, 10'd236, 24'h0000FF, "ball_right_edge");
        probe(10'd316, 10'd244, 24'h0000FF, "ball_bottom_edge");
        probe(10'd288, 10'd456, 24'h00FF00, "pad_first_px");
        probe(10'd351, 10'd463, 24'h00FF00, "pad_last_px");
        probe(10'd352, 10'd456, 24'h0000FF, "pad_right_edge");
        probe(10'd287, 10'd456, 24'h0000FF, "pad_left_edge");
        probe(10'd288, 10'd464, 24'h0000FF, "pad_bottom_edge");

        // First frame tick: exactly one cycle wide
        m_if.col_i = 10'd0; m_if.row_i = 10'd480; m_if.blank_n_i = 1'b0;
        cyc();
        chk("tick_high", {31'd0, m_if.frame_tick}, 32'd1);
        m_if.col_i = 10'd1;
        cyc();
        chk("tick_low", {31'd0, m_if.frame_tick}, 32'd0);

        tick_main(59);
        probe(10'd316, 10'd236, 24'hFFFFFF, "serve_held");
        probe(10'd324, 10'd244, 24'h0000FF, "serve_not_moved");
        tick_main(1);
        probe(10'd324, 10'd244, 24'hFFFFFF, "play_step_new");
        probe(10'd317, 10'd237, 24'h0000FF, "play_step_old");

        // Paddle left to the wall and beyond
        m_if.btn_left = 1'b1;
        tick_main(36);
        probe(10'd144, 10'd456, 24'h00FF00, "pad_mid_in");
        probe(10'd143, 10'd456, 24'h0000FF, "pad_mid_out");
        tick_main(36);
        probe(10'd0,  10'd456, 24'h00FF00, "pad_zero_in");
        probe(10'd64, 10'd456, 24'h0000FF, "pad_zero_out");
        tick_main(8);
        probe(10'd63, 10'd463, 24'h00FF00, "pad_sat_in");
        probe(10'd64, 10'd456, 24'h0000FF, "pad_sat_out");
        m_if.btn_right = 1'b1;
        tick_main(4);
        probe(10'd0,  10'd456, 24'h00FF00, "pad_both_in");
        probe(10'd64, 10'd456, 24'h0000FF, "pad_both_out");
        probe(10'd486, 10'd406, 24'hFFFFFF, "ball_k85");
        probe(10'd485, 10'd406, 24'hFFFFFF ^ 24'hFFFF00, "ball_k85_left");
        m_if.btn_left = 1'b0; m_if.btn_right = 1'b0;

        // Ball falls past the paddle at the left wall
        tick_main(20);
        chk("pre_miss_cnt", {24'd0, m_if.miss_cnt}, 32'd0);
        probe(10'd0, 10'd0, 24'h0000FF, "pre_miss_bg");
        tick_main(1);
        chk("miss_cnt_1", {24'd0, m_if.miss_cnt}, 32'd1);
        probe(10'd0,   10'd0,   24'hFF0000, "miss_bg");
        probe(10'd528, 10'd446, 24'hFF0000, "miss_no_ball");
        probe(10'd0,   10'd456, 24'h00FF00, "miss_pad");
        tick_main(29);
        probe(10'd0, 10'd0, 24'hFF0000, "miss_held_29");
        tick_main(1);
        probe(10'd0,   10'd0,   24'h0000FF, "reserve_bg");
        probe(10'd316, 10'd236, 24'hFFFFFF, "reserve_centre");
        tick_main(61);
        probe(10'd314, 10'd238, 24'hFFFFFF, "dirx_left_new");
        probe(10'd322, 10'd238, 24'h0000FF, "dirx_left_old");
        chk("miss_cnt_hold", {24'd0, m_if.miss_cnt}, 32'd1);

        // Mid-game reset
        reset = 1'b1;
        m_if.col_i = 10'd100; m_if.row_i = 10'd100; m_if.blank_n_i = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst2_miss", {24'd0, m_if.miss_cnt}, 32'd0);
        chk("rst2_rgb",  {8'd0, m_if.VGA_R, m_if.VGA_G, m_if.VGA_B}, 32'h0);
        probe(10'd316, 10'd236, 24'hFFFFFF, "rst2_ball");
        probe(10'd288, 10'd456, 24'h00FF00, "rst2_pad");
        probe(10'd287, 10'd456, 24'h0000FF, "rst2_pad_edge");

        // Paddle placed under the falling ball: bounce, then right-wall bounce
        m_if.btn_right = 1'b1;
        tick_main(50);
        m_if.btn_right = 1'b0;
        probe(10'd488, 10'd456, 24'h00FF00, "pad_488_in");
        probe(10'd487, 10'd456, 24'h0000FF, "pad_488_out");
        tick_main(116);
        chk("catch_miss_cnt", {24'd0, m_if.miss_cnt}, 32'd0);
        probe(10'd528, 10'd448, 24'hFFFFFF, "catch_top");
        probe(10'd535, 10'd455, 24'hFFFFFF, "catch_bottom");
        probe(10'd0,   10'd0,   24'h0000FF, "catch_bg");
        tick_main(1);
        probe(10'd530, 10'd446, 24'hFFFFFF, "rise_new");
        probe(10'd530, 10'd454, 24'h0000FF, "rise_old");
        tick_main(51);
        probe(10'd632, 10'd344, 24'hFFFFFF, "xwall_first");
        probe(10'd639, 10'd351, 24'hFFFFFF, "xwall_last");
        probe(10'd631, 10'd344, 24'h0000FF, "xwall_left");
        tick_main(1);
        probe(10'd630, 10'd342, 24'hFFFFFF, "xback_new");
        probe(10'd638, 10'd342, 24'h0000FF, "xback_old");
        chk("xwall_miss_cnt", {24'd0, m_if.miss_cnt}, 32'd0);

        // Miss counter saturation on the shrunken instance
        s_if.btn_left = 1'b1;
        for (int i = 0; i < 3000 && s_if.miss_cnt != 8'd255; i++) begin
            tick_sat(1);
        end
        chk("sat_reach_255", {24'd0, s_if.miss_cnt}, 32'd255);
        tick_sat(200);
        chk("sat_hold_255", {24'd0, s_if.miss_cnt}, 32'd255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
